div_sequencer: RTL and testbench

- Upstream command stage for the 8-bit/7-bit iterative divider.
- Accepts operand pairs over a valid/ready handshake and issues the divider's one-cycle start pulse.
- Presents the operands to the divider and waits the divider's fixed latency, then captures quotient/remainder.
- Returns the result on a valid/ready handshake. Divide-by-zero is trapped locally; the divider never sees a zero divisor.

---
 rtl/div_sequencer.sv | 116 +++++++++++
 tb/tb_div_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Command stage for the 8-bit/7-bit iterative divider: accepts operand pairs, pulses
// the divider start, waits its fixed latency, captures the result and traps divide-by-zero.
module div_sequencer #(
    parameter int unsigned RESULT_DELAY = 17,
    parameter logic [7:0]  DBZ_QUOTIENT = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_dividend,
    input  logic [6:0] in_divisor,
    output logic       div_start,
    output logic [7:0] div_dividend,
    output logic [6:0] div_divisor,
    input  logic [7:0] div_quotient,
    input  logic [6:0] div_remainder,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_quotient,
    output logic [6:0] out_remainder,
    output logic       out_dbz
);

    localparam int unsigned CW = (RESULT_DELAY > 1) ? $clog2(RESULT_DELAY) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(RESULT_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          armed_q;
    logic          div_start_q;
    logic [7:0]    div_dividend_q;
    logic [6:0]    div_divisor_q;
    logic          out_valid_q;
    logic [7:0]    out_quotient_q;
    logic [6:0]    out_remainder_q;
    logic          out_dbz_q;

    // armed_q keeps in_ready low until the first edge after reset releases.
    assign in_ready      = (state_q == IDLE) && armed_q;
    assign div_start     = div_start_q;
    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;
    assign out_valid     = out_valid_q;
    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign out_dbz       = out_dbz_q;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            armed_q         <= 1'b0;
            div_start_q     <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            out_valid_q     <= 1'b0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
            out_dbz_q       <= 1'b0;
        end else begin
            armed_q     <= 1'b1;
            div_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        if (in_divisor != '0) begin
                            div_dividend_q <= in_dividend;
                            div_divisor_q  <= in_divisor;
                            div_start_q    <= 1'b1;
                            state_q        <= ISSUE;
                        end else begin
                            // Zero divisor never reaches the divider.
                            out_quotient_q  <= DBZ_QUOTIENT;
                            out_remainder_q <= '0;
                            out_dbz_q       <= 1'b1;
                            out_valid_q     <= 1'b1;
                            state_q         <= HOLD;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == LAST_WAIT) begin
                        out_quotient_q  <= div_quotient;
                        out_remainder_q <= div_remainder;
                        out_dbz_q       <= 1'b0;
                        out_valid_q     <= 1'b1;
                        state_q         <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: a latency-exact divider model plus a result
// scoreboard filled at acceptance and drained on the output handshake.
module tb_div_sequencer;

    localparam int RD = 17;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_dividend;
    logic [6:0] in_divisor;
    logic       div_start;
    logic [7:0] div_dividend;
    logic [6:0] div_divisor;
    logic [7:0] div_quotient;
    logic [6:0] div_remainder;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_quotient;
    logic [6:0] out_remainder;
    logic       out_dbz;

    div_sequencer #(.RESULT_DELAY(RD), .DBZ_QUOTIENT(8'hFF)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_remainder(out_remainder),
        .out_dbz      (out_dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, act, act, exp, exp, cyc);
        end
    endtask

    // Divider model: result is correct only during the RD-th cycle after the start pulse.
    int         dcnt;
    logic [7:0] ref_q;
    logic [6:0] ref_r;
    always @(posedge clk or negedge reset) begin
        if (!reset) dcnt <= 0;
        else if (div_start) dcnt <= 1;
        else if (dcnt != 0 && dcnt < 1000) dcnt <= dcnt + 1;
    end
    always_comb begin
        ref_q = 8'd0;
        ref_r = 7'd0;
        if (div_divisor != 7'd0) begin
            ref_q = 8'(div_dividend / {1'b0, div_divisor});
            ref_r = 7'(div_dividend % {1'b0, div_divisor});
        end
        div_quotient  = (dcnt == RD) ? ref_q : (ref_q ^ 8'hA5);
        div_remainder = (dcnt == RD) ? ref_r : (ref_r ^ 7'h55);
    end

    typedef struct {
        logic [7:0] dvd;
        logic [6:0] dvs;
        logic [7:0] q;
        logic [6:0] r;
        logic       dbz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   b2b = 1'b0;
    bit   have_last = 1'b0;
    int   last_start = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (div_start) begin
                if (b2b && have_last) check("issue_spacing", 32'(cyc - last_start), 32'(RD + 3));
                last_start = cyc;
                have_last  = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("quotient", 32'(out_quotient), 32'(mon_e.q));
                    check("remainder", 32'(out_remainder), 32'(mon_e.r));
                    check("dbz", 32'(out_dbz), 32'(mon_e.dbz));
                    if (!mon_e.dbz) begin
                        check("q*d+r", 32'(out_quotient) * 32'(mon_e.dvs) + 32'(out_remainder),
                              32'(mon_e.dvd));
                        check("r<d", 32'(out_remainder < mon_e.dvs), 1);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [6:0] b, input bit keep, output int acc);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        acc         = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            check("accept_timeout", 32'(in_ready), 1);
        end else begin
            e.dvd = a;
            e.dvs = b;
            e.dbz = (b == 7'd0);
            e.q   = e.dbz ? 8'hFF : 8'(a / {1'b0, b});
            e.r   = e.dbz ? 7'd0 : 7'(a % {1'b0, b});
            sb.push_back(e);
        end
        @(posedge clk);
        if (!keep) begin
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 32'(sb.size()), 0);
        @(negedge clk);
    endtask

    logic [7:0] bd_a [4] = '{8'd0, 8'd255, 8'd127, 8'd5};
    logic [6:0] bd_b [4] = '{7'd1, 7'd1, 7'd127, 7'd127};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int seen;
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b1;

        // Reset state
        #1;
        check("rst_div_start", 32'(div_start), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_dbz", 32'(out_dbz), 0);
        check("rst_out_q", 32'(out_quotient), 0);
        check("rst_out_r", 32'(out_remainder), 0);
        check("rst_div_dvd", 32'(div_dividend), 0);
        check("rst_div_dvs", 32'(div_divisor), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("in_ready_before_edge", 32'(in_ready), 0);
        @(negedge clk);
        check("in_ready_after_edge", 32'(in_ready), 1);

        // Basic latency: 200/7
        send(8'd200, 7'd7, 1'b0, acc);
        for (int k = 1; k <= RD + 2; k++) begin
            @(negedge clk);
            check($sformatf("lat_start_%0d", k), 32'(div_start), 32'(k == 1));
            if (k <= RD + 1) begin
                check("lat_div_dvd", 32'(div_dividend), 200);
                check("lat_div_dvs", 32'(div_divisor), 7);
            end
            check($sformatf("lat_valid_%0d", k), 32'(out_valid), 32'(k == RD + 2));
        end
        drain();

        // Divide by zero
        send(8'd55, 7'd0, 1'b0, acc);
        @(negedge clk);
        check("dbz_valid", 32'(out_valid), 1);
        check("dbz_flag", 32'(out_dbz), 1);
        check("dbz_q", 32'(out_quotient), 32'hFF);
        check("dbz_r", 32'(out_remainder), 0);
        check("dbz_no_start", 32'(div_start), 0);
        @(negedge clk);
        check("dbz_no_start2", 32'(div_start), 0);
        drain();

        // Backpressure: 255/127 held for 10 cycles
        out_ready = 1'b0;
        send(8'd255, 7'd127, 1'b0, acc);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        check("bp_valid", 32'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_q", 32'(out_quotient), 2);
            check("bp_hold_r", 32'(out_remainder), 1);
            check("bp_hold_dbz", 32'(out_dbz), 0);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_ready_after", 32'(in_ready), 1);
        check("bp_valid_cleared", 32'(out_valid), 0);
        drain();

        // Reset mid-WAIT at counter 9
        send(8'd100, 7'd3, 1'b0, acc);
        repeat (11) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mrst_div_start", 32'(div_start), 0);
        check("mrst_out_valid", 32'(out_valid), 0);
        check("mrst_out_dbz", 32'(out_dbz), 0);
        check("mrst_out_q", 32'(out_quotient), 0);
        check("mrst_out_r", 32'(out_remainder), 0);
        check("mrst_div_dvd", 32'(div_dividend), 0);
        check("mrst_div_dvs", 32'(div_divisor), 0);
        check("mrst_in_ready", 32'(in_ready), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mrst_no_valid", 32'(seen), 0);
        send(8'd9, 7'd4, 1'b0, acc);
        drain();

        // Back-to-back random traffic
        b2b       = 1'b1;
        have_last = 1'b0;
        for (int n = 0; n < 40; n++) begin
            send(8'($urandom_range(0, 255)), 7'($urandom_range(1, 127)), 1'b1, acc);
        end
        #1;
        in_valid = 1'b0;
        drain();
        b2b = 1'b0;

        // Boundaries
        for (int n = 0; n < 4; n++) begin
            send(bd_a[n], bd_b[n], 1'b0, acc);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
